// File: rtl/mdio_responder_if.sv
// MDIO line and write-report signals shared by the Clause 22 responder and
// whatever drives the management bus (controller, mux or bench).
interface mdio_responder_if;
   logic        mdc;
   logic        mdio_i;
   logic        mdio_o;
   logic        mdio_tri;
   logic        wr_pulse;
   logic [4:0]  wr_regad;
   logic [15:0] wr_data;
   logic        frame_err;

   modport master (
      output mdc, mdio_i,
      input  mdio_o, mdio_tri, wr_pulse, wr_regad, wr_data, frame_err
   );

   modport slave (
      input  mdc, mdio_i,
      output mdio_o, mdio_tri, wr_pulse, wr_regad, wr_data, frame_err
   );
endinterface

// File: rtl/mdio_responder.sv
// Clause 22 MDIO PHY-side responder with a 32 x 16-bit register model.
// Optional MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN accepts a frame after a single preamble 1.
module mdio_responder #(
   parameter logic [4:0]  PHY_ADDR = 5'd0,
   parameter logic [31:0] PHY_ID   = 32'h0141_0DD0
) (
   input  logic            axi_aclk,
   input  logic            axi_aresetn,
   mdio_responder_if.slave bus
);

`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
   localparam logic [5:0] PRE_MIN = 6'd1;
`else
   localparam logic [5:0] PRE_MIN = 6'd32;
`endif

   localparam logic [2:0] S_PRE   = 3'd0;
   localparam logic [2:0] S_ST    = 3'd1;
   localparam logic [2:0] S_OP    = 3'd2;
   localparam logic [2:0] S_PHYAD = 3'd3;
   localparam logic [2:0] S_REGAD = 3'd4;
   localparam logic [2:0] S_TA    = 3'd5;
   localparam logic [2:0] S_DATA  = 3'd6;

   logic        mdc_s1, mdc_s2, mdc_s3;
   logic        mdio_s1, mdio_s2;
   logic        rise;
   logic [2:0]  state;
   logic [5:0]  pre_cnt;
   logic [4:0]  bit_cnt;
   logic        op_hi;
   logic        is_read;
   logic        match;
   logic [3:0]  phyad;
   logic [4:0]  regad;
   logic [4:0]  phy_next;
   logic [15:0] rd_shift;
   logic [14:0] wr_shift;
   logic [15:0] wr_word;
   logic        drive;
   logic [15:0] regs [32];

   logic        mdio_o_q, mdio_tri_q, wr_pulse_q, frame_err_q;
   logic [4:0]  wr_regad_q;
   logic [15:0] wr_data_q;

   function automatic logic [5:0] pre_sat(input logic [5:0] c);
      return (c == 6'd32) ? c : c + 6'd1;
   endfunction

   function automatic logic [15:0] reg_read(input logic [4:0] a);
      case (a)
         5'd2:    return PHY_ID[31:16];
         5'd3:    return PHY_ID[15:0];
         default: return regs[a];
      endcase
   endfunction

   assign rise     = mdc_s2 & ~mdc_s3;
   assign phy_next = {phyad, mdio_s2};
   assign wr_word  = {wr_shift, mdio_s2};
   assign drive    = is_read & match;

   assign bus.mdio_o    = mdio_o_q;
   assign bus.mdio_tri  = mdio_tri_q;
   assign bus.wr_pulse  = wr_pulse_q;
   assign bus.wr_regad  = wr_regad_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.frame_err = frame_err_q;

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         mdc_s1      <= 1'b0;
         mdc_s2      <= 1'b0;
         mdc_s3      <= 1'b0;
         mdio_s1     <= 1'b1;
         mdio_s2     <= 1'b1;
         state       <= S_PRE;
         pre_cnt     <= '0;
         bit_cnt     <= '0;
         op_hi       <= 1'b0;
         is_read     <= 1'b0;
         match       <= 1'b0;
         phyad       <= '0;
         regad       <= '0;
         rd_shift    <= '0;
         wr_shift    <= '0;
         mdio_o_q    <= 1'b0;
         mdio_tri_q  <= 1'b1;
         wr_pulse_q  <= 1'b0;
         frame_err_q <= 1'b0;
         wr_regad_q  <= '0;
         wr_data_q   <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         mdc_s1      <= bus.mdc;
         mdc_s2      <= mdc_s1;
         mdc_s3      <= mdc_s2;
         mdio_s1     <= bus.mdio_i;
         mdio_s2     <= mdio_s1;
         wr_pulse_q  <= 1'b0;
         frame_err_q <= 1'b0;

         if (rise) begin
            case (state)
               S_PRE: begin
                  if (mdio_s2) begin
                     pre_cnt <= pre_sat(pre_cnt);
                  end else begin
                     // The 0 that ends a full preamble is the first ST bit
                     if (pre_cnt >= PRE_MIN) state <= S_ST;
                     pre_cnt <= '0;
                  end
               end
               S_ST: begin
                  if (mdio_s2) begin
                     state   <= S_OP;
                     bit_cnt <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= S_PRE;
                  end
               end
               S_OP: begin
                  if (bit_cnt == 5'd0) begin
                     op_hi   <= mdio_s2;
                     bit_cnt <= 5'd1;
                  end else if (op_hi != mdio_s2) begin
                     is_read <= op_hi;
                     state   <= S_PHYAD;
                     bit_cnt <= '0;
                  end else begin
                     frame_err_q <= 1'b1;
                     state       <= S_PRE;
                     bit_cnt     <= '0;
                  end
               end
               S_PHYAD: begin
                  phyad <= phy_next[3:0];
                  if (bit_cnt == 5'd4) begin
                     match   <= (phy_next == PHY_ADDR);
                     state   <= S_REGAD;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               S_REGAD: begin
                  regad <= {regad[3:0], mdio_s2};
                  if (bit_cnt == 5'd4) begin
                     state   <= S_TA;
                     bit_cnt <= '0;
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                  end
               end
               S_TA: begin
                  if (bit_cnt == 5'd0) begin
                     bit_cnt <= 5'd1;
                     // Take the line for TA bit 2, which is always driven 0
                     if (drive) begin
                        mdio_tri_q <= 1'b0;
                        mdio_o_q   <= 1'b0;
                        rd_shift   <= reg_read(regad);
                     end
                  end else begin
                     state   <= S_DATA;
                     bit_cnt <= '0;
                     if (drive) begin
                        mdio_o_q <= rd_shift[15];
                        rd_shift <= {rd_shift[14:0], 1'b0};
                     end
                  end
               end
               S_DATA: begin
                  wr_shift <= {wr_shift[13:0], mdio_s2};
                  if (bit_cnt == 5'd15) begin
                     state   <= S_PRE;
                     pre_cnt <= '0;
                     bit_cnt <= '0;
                     if (drive) begin
                        mdio_tri_q <= 1'b1;
                        mdio_o_q   <= 1'b0;
                     end
                     if (!is_read && match && regad != 5'd2 && regad != 5'd3) begin
                        // Reg 0 bit 15 is self-clearing soft reset: never stored
                        regs[regad] <= (regad == 5'd0) ? {1'b0, wr_word[14:0]} : wr_word;
                        wr_pulse_q  <= 1'b1;
                        wr_regad_q  <= regad;
                        wr_data_q   <= wr_word;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + 5'd1;
                     if (drive) begin
                        mdio_o_q <= rd_shift[15];
                        rd_shift <= {rd_shift[14:0], 1'b0};
                     end
                  end
               end
               default: begin
                  state   <= S_PRE;
                  pre_cnt <= '0;
                  bit_cnt <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: plays an MDIO controller on a pulled-up
// shared line and checks register reads/writes, turnaround timing and errors.
`timescale 1ns/1ps
module tb_mdio_responder;
   localparam logic [4:0] PHY = 5'd5;

   logic axi_aclk    = 1'b0;
   logic axi_aresetn = 1'b0;
   logic ctrl_oe     = 1'b0;
   logic ctrl_bit    = 1'b1;
   logic mdio_line;
   int   n_checks    = 0;
   int   n_fail      = 0;
   int   wr_cnt      = 0;
   int   ferr_cnt    = 0;

   mdio_responder_if bus();

   mdio_responder #(.PHY_ADDR(PHY)) dut (
      .axi_aclk    (axi_aclk),
      .axi_aresetn (axi_aresetn),
      .bus         (bus)
   );

   always #5 axi_aclk = ~axi_aclk;

   // Open-drain style line: responder wins when driving, else controller, else pull-up
   assign mdio_line  = !bus.mdio_tri ? bus.mdio_o : (ctrl_oe ? ctrl_bit : 1'b1);
   assign bus.mdio_i = mdio_line;

   always @(posedge axi_aclk) begin
      if (bus.wr_pulse)  wr_cnt++;
      if (bus.frame_err) ferr_cnt++;
   end

   // One MDC period: data set with the falling edge, line sampled just before rising edge
   task automatic mdc_cycle(input logic b, input logic drv, output logic line_s, output logic tri_s);
      bus.mdc  = 1'b0;
      ctrl_oe  = drv;
      ctrl_bit = b;
      #79;
      line_s = mdio_line;
      tri_s  = bus.mdio_tri;
      #1 bus.mdc = 1'b1;
      #80;
   endtask

   task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd,
                            output logic [15:0] rd, output int drv_cnt, output logic ta2);
      logic        l, t, wr;
      logic [13:0] hdr;
      wr      = (op == 2'b01);
      hdr     = {2'b01, op, phy, ra};
      drv_cnt = 0;
      rd      = '0;
      ta2     = 1'b1;
      @(negedge axi_aclk);
      for (int i = 0; i < npre; i++) begin
         mdc_cycle(1'b1, 1'b1, l, t);
         if (!t) drv_cnt++;
      end
      for (int i = 13; i >= 0; i--) begin
         mdc_cycle(hdr[i], 1'b1, l, t);
         if (!t) drv_cnt++;
      end
      for (int i = 0; i < 2; i++) begin
         mdc_cycle(i == 0, wr, l, t);
         if (!t) drv_cnt++;
         if (i == 1) ta2 = l;
      end
      for (int i = 15; i >= 0; i--) begin
         mdc_cycle(wd[i], wr, l, t);
         if (!t) drv_cnt++;
         rd[i] = l;
      end
      ctrl_oe = 1'b0;
      if (!bus.mdio_tri) drv_cnt++;
   endtask

   task automatic test_reset();
      bus.mdc = 1'b0;
      #23;
      n_checks++; if (bus.mdio_o !== 1'b0)     begin n_fail++; $display("FAIL reset_mdio_o got %b want 0", bus.mdio_o); end
      n_checks++; if (bus.mdio_tri !== 1'b1)   begin n_fail++; $display("FAIL reset_mdio_tri got %b want 1", bus.mdio_tri); end
      n_checks++; if (bus.wr_pulse !== 1'b0)   begin n_fail++; $display("FAIL reset_wr_pulse got %b want 0", bus.wr_pulse); end
      n_checks++; if (bus.wr_regad !== 5'd0)   begin n_fail++; $display("FAIL reset_wr_regad got %h want 0", bus.wr_regad); end
      n_checks++; if (bus.wr_data !== 16'h0)   begin n_fail++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
      n_checks++; if (bus.frame_err !== 1'b0)  begin n_fail++; $display("FAIL reset_frame_err got %b want 0", bus.frame_err); end
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      repeat (4) @(negedge axi_aclk);
   endtask

   task automatic test_write_read();
      logic [15:0] rd; int dc; logic ta; int w0;
      w0 = wr_cnt;
      run_frame(32, 2'b01, PHY, 5'd4, 16'hA5C3, rd, dc, ta);
      n_checks++; if (wr_cnt - w0 !== 1)        begin n_fail++; $display("FAIL wr4_pulses got %0d want 1", wr_cnt - w0); end
      n_checks++; if (bus.wr_regad !== 5'd4)    begin n_fail++; $display("FAIL wr4_regad got %h want 4", bus.wr_regad); end
      n_checks++; if (bus.wr_data !== 16'hA5C3) begin n_fail++; $display("FAIL wr4_data got %h want a5c3", bus.wr_data); end
      n_checks++; if (dc !== 0)                 begin n_fail++; $display("FAIL wr4_drive got %0d want 0", dc); end
      run_frame(32, 2'b10, PHY, 5'd4, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'hA5C3)          begin n_fail++; $display("FAIL rd4_data got %h want a5c3", rd); end
      n_checks++; if (dc !== 17)                begin n_fail++; $display("FAIL rd4_drive got %0d want 17", dc); end
   endtask

   task automatic test_phy_id();
      logic [15:0] rd; int dc; logic ta; int w0;
      w0 = wr_cnt;
      run_frame(32, 2'b01, PHY, 5'd2, 16'hFFFF, rd, dc, ta);
      n_checks++; if (wr_cnt - w0 !== 0)  begin n_fail++; $display("FAIL wr2_dropped got %0d pulses want 0", wr_cnt - w0); end
      run_frame(32, 2'b10, PHY, 5'd2, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'h0141)    begin n_fail++; $display("FAIL rd2_data got %h want 0141", rd); end
      n_checks++; if (dc !== 17)          begin n_fail++; $display("FAIL rd2_drive got %0d want 17", dc); end
      n_checks++; if (ta !== 1'b0)        begin n_fail++; $display("FAIL rd2_ta2 got %b want 0", ta); end
      run_frame(32, 2'b10, PHY, 5'd3, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'h0DD0)    begin n_fail++; $display("FAIL rd3_data got %h want 0dd0", rd); end
      n_checks++; if (dc !== 17)          begin n_fail++; $display("FAIL rd3_drive got %0d want 17", dc); end
      n_checks++; if (ta !== 1'b0)        begin n_fail++; $display("FAIL rd3_ta2 got %b want 0", ta); end
   endtask

   task automatic test_mismatch();
      logic [15:0] rd; int dc; logic ta; int w0;
      w0 = wr_cnt;
      run_frame(32, 2'b01, PHY ^ 5'd1, 5'd4, 16'h1234, rd, dc, ta);
      n_checks++; if (wr_cnt - w0 !== 0)  begin n_fail++; $display("FAIL mis_wr_pulse got %0d want 0", wr_cnt - w0); end
      n_checks++; if (dc !== 0)           begin n_fail++; $display("FAIL mis_wr_drive got %0d want 0", dc); end
      run_frame(32, 2'b10, PHY ^ 5'd1, 5'd4, 16'h0, rd, dc, ta);
      n_checks++; if (dc !== 0)           begin n_fail++; $display("FAIL mis_rd_drive got %0d want 0", dc); end
      run_frame(32, 2'b10, PHY, 5'd4, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'hA5C3)    begin n_fail++; $display("FAIL mis_reg4_kept got %h want a5c3", rd); end
   endtask

   task automatic test_frame_err();
      logic [15:0] rd; int dc; logic ta; int f0; logic l, t;
      f0 = ferr_cnt;
      @(negedge axi_aclk);
      for (int i = 0; i < 32; i++) mdc_cycle(1'b1, 1'b1, l, t);
      mdc_cycle(1'b0, 1'b1, l, t);
      mdc_cycle(1'b1, 1'b1, l, t);
      mdc_cycle(1'b1, 1'b1, l, t);
      mdc_cycle(1'b1, 1'b1, l, t);
      ctrl_oe = 1'b0;
      #200;
      n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL op11_err got %0d want 1", ferr_cnt - f0); end
      @(negedge axi_aclk);
      for (int i = 0; i < 32; i++) mdc_cycle(1'b1, 1'b1, l, t);
      mdc_cycle(1'b0, 1'b1, l, t);
      mdc_cycle(1'b0, 1'b1, l, t);
      ctrl_oe = 1'b0;
      #200;
      n_checks++; if (ferr_cnt - f0 !== 2) begin n_fail++; $display("FAIL st_err got %0d want 2", ferr_cnt - f0); end
      run_frame(32, 2'b10, PHY, 5'd3, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'h0DD0)     begin n_fail++; $display("FAIL err_rd3_data got %h want 0dd0", rd); end
      n_checks++; if (ferr_cnt - f0 !== 2) begin n_fail++; $display("FAIL err_no_extra got %0d want 2", ferr_cnt - f0); end
   endtask

   task automatic test_short_preamble();
      logic [15:0] rd; int dc; logic ta;
      run_frame(31, 2'b10, PHY, 5'd2, 16'h0, rd, dc, ta);
`ifdef MDIO_RESPONDER_PREAMBLE_SUPPRESS_EN
      n_checks++; if (dc !== 17)         begin n_fail++; $display("FAIL pre31_drive got %0d want 17", dc); end
      n_checks++; if (rd !== 16'h0141)   begin n_fail++; $display("FAIL pre31_data got %h want 0141", rd); end
`else
      n_checks++; if (dc !== 0)          begin n_fail++; $display("FAIL pre31_drive got %0d want 0", dc); end
      n_checks++; if (rd !== 16'hFFFF)   begin n_fail++; $display("FAIL pre31_data got %h want ffff", rd); end
`endif
   endtask

   task automatic test_reset_mid_read();
      logic [15:0] rd; int dc; logic ta; logic l, t; logic [13:0] hdr; int w0;
      hdr = {2'b01, 2'b10, PHY, 5'd4};
      @(negedge axi_aclk);
      for (int i = 0; i < 32; i++) mdc_cycle(1'b1, 1'b1, l, t);
      for (int i = 13; i >= 0; i--) mdc_cycle(hdr[i], 1'b1, l, t);
      for (int i = 0; i < 9; i++) mdc_cycle(1'b1, 1'b0, l, t);
      n_checks++; if (t !== 1'b0)           begin n_fail++; $display("FAIL mid_driving got tri=%b want 0", t); end
      bus.mdc = 1'b0;
      ctrl_oe = 1'b0;
      #40;
      axi_aresetn = 1'b0;
      #1;
      n_checks++; if (bus.mdio_tri !== 1'b1) begin n_fail++; $display("FAIL mid_async_tri got %b want 1", bus.mdio_tri); end
      #99;
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      repeat (4) @(negedge axi_aclk);
      run_frame(32, 2'b10, PHY, 5'd4, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'h0000)      begin n_fail++; $display("FAIL rst_reg4 got %h want 0000", rd); end
      n_checks++; if (dc !== 17)            begin n_fail++; $display("FAIL rst_rd_drive got %0d want 17", dc); end
      w0 = wr_cnt;
      run_frame(32, 2'b01, PHY, 5'd0, 16'h8001, rd, dc, ta);
      n_checks++; if (wr_cnt - w0 !== 1)    begin n_fail++; $display("FAIL wr0_pulses got %0d want 1", wr_cnt - w0); end
      n_checks++; if (bus.wr_data !== 16'h8001) begin n_fail++; $display("FAIL wr0_raw got %h want 8001", bus.wr_data); end
      n_checks++; if (bus.wr_regad !== 5'd0) begin n_fail++; $display("FAIL wr0_regad got %h want 0", bus.wr_regad); end
      run_frame(32, 2'b10, PHY, 5'd0, 16'h0, rd, dc, ta);
      n_checks++; if (rd !== 16'h0001)      begin n_fail++; $display("FAIL rd0_softrst got %h want 0001", rd); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_phy_id();
      test_mismatch();
      test_frame_err();
      test_short_preamble();
      test_reset_mid_read();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
